// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Flush squashes held entries to a bubble. A saturating counter tracks downstream stall cycles.
module pipe_stage_buf #(
  parameter int unsigned       WIDTH     = 64,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic main_v;
  logic skid_v;
  logic push;
  logic pop;
  logic stall;

  assign main_v = (state_q != StEmpty);
  assign skid_v = (state_q == StFull);

  // in_ready never looks at out_ready: the skid entry absorbs the one-cycle lag.
  assign in_ready = !reset && !flush && !skid_v;
  assign push     = in_valid && in_ready;
  assign pop      = main_v && out_ready;
  assign stall    = main_v && !out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    case (state_q)
      StEmpty: begin
        if (push) begin
          main_data_d = in_data;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_data_d = in_data;
        end else if (push) begin
          skid_data_d = in_data;
          state_d     = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          main_data_d = skid_data_q;
          state_d     = StOne;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_data_q <= NOP_VALUE;
      skid_data_q <= NOP_VALUE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_v ? main_data_q : NOP_VALUE;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus random traffic,
// all compared against a queue-based model of a two-deep in-order buffer.
module tb_pipe_stage_buf;

  localparam logic [7:0] Nop = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, in_valid, flush, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [7:0] stall_cnt;
  logic       sat_in_ready, sat_out_valid;
  logic [7:0] sat_out_data;
  logic [2:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  // Model: an in-order queue holding at most two payloads, plus a raw stall tally.
  logic [7:0]  mq[$];
  int unsigned mcnt;
  logic        obs_in_ready, exp_in_ready;

  pipe_stage_buf #(.WIDTH(8), .NOP_VALUE(Nop), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.WIDTH(8), .NOP_VALUE(Nop), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .stall_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [7:0] exp_data();
    return (mq.size() > 0) ? mq[0] : Nop;
  endfunction

  function automatic int unsigned exp_cnt(input int unsigned w);
    int unsigned lim;
    lim = (1 << w) - 1;
    return (mcnt > lim) ? lim : mcnt;
  endfunction

  // Drive one cycle of inputs, sample in_ready before the edge, advance the model at the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic fl,
                      input logic rst);
    bit pop, push;
    in_valid = v; in_data = d; out_ready = rdy; flush = fl; reset = rst;
    #1;
    obs_in_ready = in_ready;
    exp_in_ready = !rst && !fl && (mq.size() < 2);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (mq.size() > 0 && !rdy) mcnt++;
      pop  = (mq.size() > 0) && rdy;
      push = v && exp_in_ready;
      if (fl) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h78, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", obs_in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== Nop || stall_cnt !== 8'd0 || sat_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h c=%0d sc=%0d want v=0 d=%h c=0 sc=0",
               out_valid, out_data, stall_cnt, sat_cnt, Nop);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready got %b want 1", obs_in_ready);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] pay[3];
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pay[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== pay[i] || stall_cnt !== 8'd0
          || obs_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h c=%0d ir=%b want v=1 d=%h c=0 ir=1",
                 i, out_valid, out_data, stall_cnt, obs_in_ready, pay[i]);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== Nop) begin
      errors++; $display("FAIL stream_drain got v=%b d=%h want v=0 d=%h", out_valid, out_data, Nop);
    end
  endtask

  task automatic test_skid();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_in_ready !== 1'b0 || out_data !== 8'hA1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL skid_hold_%0d got ir=%b d=%h v=%b want ir=0 d=a1 v=1",
                 i, obs_in_ready, out_data, out_valid);
      end
    end
    checks++;
    if (stall_cnt !== 8'd4 || sat_cnt !== 3'd4) begin
      errors++; $display("FAIL skid_stall_cnt got %0d/%0d want 4/4", stall_cnt, sat_cnt);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2) begin
      errors++; $display("FAIL skid_second got v=%b d=%h want v=1 d=b2", out_valid, out_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_recover got ir=%b v=%b want ir=1 v=0", obs_in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got %b want 0", obs_in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== Nop) begin
      errors++; $display("FAIL flush_bubble got v=%b d=%h want v=0 d=%h", out_valid, out_data, Nop);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_data === 8'h55) begin
        errors++; $display("FAIL flush_leak_%0d got v=%b d=%h want v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h10) begin
        errors++;
        $display("FAIL push_pop_%0d got ir=%b v=%b d=%h want ir=1 v=1 d=10",
                 i, obs_in_ready, out_valid, out_data);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (32'(sat_cnt) !== ((i < 7) ? i : 7) || 32'(stall_cnt) !== i) begin
        errors++;
        $display("FAIL saturate_%0d got sat=%0d cnt=%0d want sat=%0d cnt=%0d",
                 i, sat_cnt, stall_cnt, (i < 7) ? i : 7, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD3, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_in_ready !== 1'b1 || out_valid !== 1'b0 || stall_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got ir=%b v=%b c=%0d want ir=1 v=0 c=0",
               obs_in_ready, out_valid, stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_leak_%0d got v=%b d=%h want v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    logic v, rdy, fl, rst;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      d   = 8'($urandom);
      step(v, d, rdy, fl, rst);
      checks++;
      if (obs_in_ready !== exp_in_ready || out_valid !== exp_valid() || out_data !== exp_data()
          || 32'(stall_cnt) !== exp_cnt(8) || 32'(sat_cnt) !== exp_cnt(3)) begin
        errors++;
        $display("FAIL random_%0d got ir=%b v=%b d=%h c=%0d sc=%0d want ir=%b v=%b d=%h c=%0d sc=%0d",
                 i, obs_in_ready, out_valid, out_data, stall_cnt, sat_cnt,
                 exp_in_ready, exp_valid(), exp_data(), exp_cnt(8), exp_cnt(3));
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    mcnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_push_pop();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
